// File: rtl/cpu_debug_host_pkg.sv
// rtl/cpu_debug_host_pkg.sv - shared types and constants for the debug host shifter
package cpu_debug_host_pkg;

  localparam int DR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  // Virtual IR codes understood by the CPU debug slave
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RSP
  } state_e;

endpackage

// File: rtl/cpu_debug_host_tck_gen.sv
// rtl/cpu_debug_host_tck_gen.sv - divided test clock with sample/fall strobes
// Ports: clk, reset_n; en_i runs the divider (cleared while low);
// tck_o low phase first, sample_en_o on last low clk, fall_en_o on last high clk.
module cpu_debug_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tck_o,
  output logic sample_en_o,
  output logic fall_en_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       last_w;

  assign last_w = (cnt_q == 8'(TCK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (last_w) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o       = tck_q;
  // Both pulses mark the clk at whose end tck toggles
  assign sample_en_o = en_i && !tck_q && last_w;
  assign fall_en_o   = en_i &&  tck_q && last_w;

endmodule

// File: rtl/cpu_debug_host_shifter.sv
// rtl/cpu_debug_host_shifter.sv - virtual-JTAG scan initiator for the CPU debug slave
// Ports: clk, reset_n; cmd_valid/cmd_ready/cmd_ir/cmd_dr/cmd_ir_only command;
// rsp_valid/rsp_ready/rsp_dr response; vji_tck/tdi/tdo, vji_ir_in, strobes, vji_rti.
module cpu_debug_host_shifter
  import cpu_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = $clog2(DR_WIDTH);

  state_e              state_q, state_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                ir_only_q, ir_only_d;
  logic                cmd_ready_q, rsp_valid_q, tdi_q, rti_q;
  logic                uir_q, cdr_q, sdr_q, udr_q;
  logic                scan_en, sample_en, fall_en;

  assign scan_en = (state_q inside {UIR, CDR, SDR, UDR});

  cpu_debug_host_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (scan_en),
    .tck_o       (vji_tck),
    .sample_en_o (sample_en),
    .fall_en_o   (fall_en)
  );

  // Every scan state ends on a tck falling edge, so tck is already low on exit
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cap_d     = cap_q;
    bit_d     = bit_q;
    ir_d      = ir_q;
    ir_only_d = ir_only_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = UIR;
          ir_d      = cmd_ir;
          shift_d   = cmd_dr;
          cap_d     = '0;
          bit_d     = '0;
          ir_only_d = cmd_ir_only;
        end
      end
      UIR: if (fall_en) state_d = ir_only_q ? RSP : CDR;
      CDR: if (fall_en) state_d = SDR;
      SDR: begin
        if (sample_en) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
        if (fall_en) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DR_WIDTH - 1)) state_d = UDR;
          else                            bit_d   = bit_q + BW'(1);
        end
      end
      UDR: if (fall_en) state_d = RSP;
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they change on the same edge as the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cap_q       <= '0;
      bit_q       <= '0;
      ir_q        <= '0;
      ir_only_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      tdi_q       <= 1'b0;
      rti_q       <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      bit_q       <= bit_d;
      ir_q        <= ir_d;
      ir_only_q   <= ir_only_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RSP);
      tdi_q       <= (state_d == SDR) && shift_d[0];
      rti_q       <= (state_d == IDLE);
      uir_q       <= (state_d == UIR);
      cdr_q       <= (state_d == CDR);
      sdr_q       <= (state_d == SDR);
      udr_q       <= (state_d == UDR);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = cap_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule

// File: tb/tb_cpu_debug_host_shifter.sv
// tb/tb_cpu_debug_host_shifter.sv - self-checking bench for cpu_debug_host_shifter
module tb_cpu_debug_host_shifter;

  localparam int DW = 38;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic [IW-1:0] cmd_ir;
  logic [DW-1:0] cmd_dr;
  logic          cmd_ir_only;
  logic          rsp_ready;

  logic          cmd_ready[2], rsp_valid[2], tck[2], tdi[2], tdo[2];
  logic          uir[2], cdr[2], sdr[2], udr[2], rti[2];
  logic [DW-1:0] rsp_dr[2];
  logic [IW-1:0] ir_in[2];

  logic [DW-1:0] sr[2];
  logic          tck_prev[2];
  logic [DW-1:0] preload;

  int checks = 0;
  int errors = 0;
  int lat[2];
  int rises, n_uir, n_cdr, n_sdr, n_udr, tdi_bad;

  always #5 clk = ~clk;

  cpu_debug_host_shifter #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_ir_only(cmd_ir_only),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr[0]),
    .vji_tck(tck[0]), .vji_tdi(tdi[0]), .vji_tdo(tdo[0]), .vji_ir_in(ir_in[0]),
    .vji_uir(uir[0]), .vji_cdr(cdr[0]), .vji_sdr(sdr[0]), .vji_udr(udr[0]), .vji_rti(rti[0])
  );

  cpu_debug_host_shifter #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_ir_only(cmd_ir_only),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr[1]),
    .vji_tck(tck[1]), .vji_tdi(tdi[1]), .vji_tdo(tdo[1]), .vji_ir_in(ir_in[1]),
    .vji_uir(uir[1]), .vji_cdr(cdr[1]), .vji_sdr(sdr[1]), .vji_udr(udr[1]), .vji_rti(rti[1])
  );

  // Behavioural debug slave: tdo = sr[0], shifts on each tck rise while sdr is high
  for (genvar g = 0; g < 2; g++) begin : g_slave
    assign tdo[g] = sr[g][0];
    always @(negedge clk) begin
      tck_prev[g] <= tck[g];
      if (cmd_ready[g]) sr[g] <= preload;
      else if (tck[g] && !tck_prev[g] && sdr[g]) sr[g] <= {tdi[g], sr[g][DW-1:1]};
    end
  end

  function automatic int exp_lat(input int div, input logic only);
    return only ? 1 + 2 * div : 1 + (DW + 3) * 2 * div;
  endfunction

  function automatic logic [DW-1:0] rnd_dr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic send(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic only,
                      input logic [DW-1:0] pre);
    @(negedge clk);
    preload = pre;
    @(negedge clk);
    cmd_ir = ir; cmd_dr = dr; cmd_ir_only = only; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready[0] !== 1'b1 || cmd_ready[1] !== 1'b1) begin
      errors++; $display("FAIL send_ready got %b%b exp 11", cmd_ready[0], cmd_ready[1]);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_dr = rnd_dr(); cmd_ir = ~ir; cmd_ir_only = ~only;
  endtask

  task automatic watch(input int limit);
    logic p0;
    p0 = 1'b0; lat[0] = -1; lat[1] = -1;
    rises = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; tdi_bad = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (tck[0] && !p0) rises++;
      p0 = tck[0];
      if (uir[0]) n_uir++;
      if (cdr[0]) n_cdr++;
      if (sdr[0]) n_sdr++;
      if (udr[0]) n_udr++;
      if (tdi[0] && !sdr[0]) tdi_bad++;
      for (int g = 0; g < 2; g++) if (rsp_valid[g] && lat[g] < 0) lat[g] = c;
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
  endtask

  task automatic consume();
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if (cmd_ready[0] !== 1'b1 || rti[0] !== 1'b1 || rsp_valid[0] !== 1'b0 ||
        cmd_ready[1] !== 1'b1 || rti[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL consume_idle got rdy %b%b rti %b%b vld %b%b exp 11 11 00",
               cmd_ready[0], cmd_ready[1], rti[0], rti[1], rsp_valid[0], rsp_valid[1]);
    end
  endtask

  // Full scan with randomised or fixed data, checked on both divider settings
  task automatic scan_and_check(input string nm, input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                                input logic only, input logic [DW-1:0] pre);
    logic [DW-1:0] exp_rsp, exp_sr;
    exp_rsp = only ? '0 : pre;
    exp_sr  = only ? pre : dr;
    send(ir, dr, only, pre);
    watch(400);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (lat[g] !== exp_lat(g == 0 ? 2 : 1, only)) begin
        errors++; $display("FAIL %s_latency%0d got %0d exp %0d", nm, g, lat[g], exp_lat(g == 0 ? 2 : 1, only));
      end
      checks++;
      if (rsp_dr[g] !== exp_rsp) begin
        errors++; $display("FAIL %s_rsp_dr%0d got %h exp %h", nm, g, rsp_dr[g], exp_rsp);
      end
      checks++;
      if (sr[g] !== exp_sr) begin
        errors++; $display("FAIL %s_slave_sr%0d got %h exp %h", nm, g, sr[g], exp_sr);
      end
      checks++;
      if (ir_in[g] !== ir) begin
        errors++; $display("FAIL %s_ir_in%0d got %b exp %b", nm, g, ir_in[g], ir);
      end
    end
    checks++;
    if (tdi_bad !== 0) begin
      errors++; $display("FAIL %s_tdi_outside_sdr got %0d exp 0", nm, tdi_bad);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_dr = rnd_dr(); cmd_ir_only = 1'b1;
    rsp_ready = 1'b0; preload = rnd_dr();
    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (cmd_ready[g] !== 1'b1 || rti[g] !== 1'b1 || tck[g] !== 1'b0 || rsp_valid[g] !== 1'b0 ||
          {uir[g], cdr[g], sdr[g], udr[g]} !== 4'b0 || rsp_dr[g] !== '0 || ir_in[g] !== '0 ||
          tdi[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state%0d got rdy %b rti %b tck %b vld %b strb %b%b%b%b rsp %h ir %b exp 1 1 0 0 0000 0 0",
                 g, cmd_ready[g], rti[g], tck[g], rsp_valid[g], uir[g], cdr[g], sdr[g], udr[g], rsp_dr[g], ir_in[g]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b0 || uir[0] !== 1'b1 || rti[0] !== 1'b0 || ir_in[0] !== 2'b11) begin
      errors++; $display("FAIL reset_release_accept got rdy %b uir %b rti %b ir %b exp 0 1 0 11",
                         cmd_ready[0], uir[0], rti[0], ir_in[0]);
    end
    cmd_valid = 1'b0;
    watch(20);
    checks++;
    if (lat[0] !== exp_lat(2, 1'b1) - 1) begin
      errors++; $display("FAIL reset_release_rsp got %0d exp %0d", lat[0], exp_lat(2, 1'b1) - 1);
    end
    consume();
  endtask

  task automatic test_dr_scan();
    scan_and_check("dr_scan", 2'b10, 38'h15_1234_5678, 1'b0, 38'h2A_5A5A_5A5A);
    checks++;
    if (rises !== DW + 3) begin
      errors++; $display("FAIL dr_scan_tck_rises got %0d exp %0d", rises, DW + 3);
    end
    checks++;
    if (n_uir !== 4 || n_cdr !== 4 || n_sdr !== DW * 4 || n_udr !== 4) begin
      errors++; $display("FAIL dr_scan_strobe_len got %0d/%0d/%0d/%0d exp 4/4/%0d/4",
                         n_uir, n_cdr, n_sdr, n_udr, DW * 4);
    end
    consume();
  endtask

  task automatic test_ir_only();
    scan_and_check("ir_only", 2'b01, rnd_dr(), 1'b1, rnd_dr());
    checks++;
    if (rises !== 1 || n_uir !== 4 || n_cdr !== 0 || n_sdr !== 0 || n_udr !== 0) begin
      errors++; $display("FAIL ir_only_strobes got rises %0d %0d/%0d/%0d/%0d exp 1 4/0/0/0",
                         rises, n_uir, n_cdr, n_sdr, n_udr);
    end
    consume();
    repeat (5) @(negedge clk);
    checks++;
    if (ir_in[0] !== 2'b01 || ir_in[1] !== 2'b01) begin
      errors++; $display("FAIL ir_only_ir_held got %b %b exp 01", ir_in[0], ir_in[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pre;
    pre = rnd_dr();
    scan_and_check("bp", 2'(($urandom())), rnd_dr(), 1'b0, pre);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_dr[0] !== pre || cmd_ready[0] !== 1'b0 || tck[0] !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got vld %b rsp %h rdy %b tck %b exp 1 %h 0 0",
                           c, rsp_valid[0], rsp_dr[0], cmd_ready[0], tck[0], pre);
      end
    end
    consume();
  endtask

  task automatic test_reset_mid_sdr();
    send(2'b00, rnd_dr(), 1'b0, rnd_dr());
    // cycle 79 lies in the high phase of SDR bit 17 for TCK_DIV=2
    repeat (79) @(negedge clk);
    checks++;
    if (sdr[0] !== 1'b1 || tck[0] !== 1'b1) begin
      errors++; $display("FAIL mid_sdr_precond got sdr %b tck %b exp 1 1", sdr[0], tck[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tck[0] !== 1'b0 || sdr[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1 ||
        tck[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
      errors++; $display("FAIL mid_sdr_reset got tck %b sdr %b vld %b rdy %b tck1 %b vld1 %b exp 0 0 0 1 0 0",
                         tck[0], sdr[0], rsp_valid[0], cmd_ready[0], tck[1], rsp_valid[1]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    scan_and_check("after_reset", 2'b11, rnd_dr(), 1'b0, rnd_dr());
    consume();
  endtask

  task automatic test_random_scans();
    for (int i = 0; i < 4; i++) begin
      scan_and_check($sformatf("rand%0d", i), 2'($urandom()), rnd_dr(), 1'($urandom_range(0, 1)), rnd_dr());
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_dr_scan();
    test_ir_only();
    test_backpressure();
    test_reset_mid_sdr();
    test_random_scans();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_debug_host_shifter.md
Name: cpu_debug_host_shifter

Overview:
On-chip initiator for the CPU debug slave's virtual-JTAG interface, running entirely on the system clock. It accepts IR/DR scan commands from a bus-side controller and generates the vji_* strobes, tck and tdi that the debug slave's tck logic expects. It captures tdo during each DR shift and returns the captured word. It is used for self-test and debugger-less bring-up, driving the same 2-bit IR and 38-bit DR protocol the slave implements.

Parameters:
DR_WIDTH, 38, scan-chain length in bits; shift count per DR scan.
IR_WIDTH, 2, virtual IR width.
TCK_DIV, 2, clk cycles per tck half-period; legal range 1..255.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
cmd_ir  in  IR_WIDTH  IR value for the scan.
cmd_dr  in  DR_WIDTH  DR data to shift in, LSB first.
cmd_ir_only  in  1  1 = UIR only; skip CDR/SDR/UDR.
rsp_valid  out  1  response holding.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_dr  out  DR_WIDTH  captured tdo bits; bit i = i-th bit shifted out.
vji_tck  out  1  generated test clock.
vji_tdi  out  1  serial data to the slave.
vji_tdo  in  1  serial data from the slave.
vji_ir_in  out  IR_WIDTH  virtual IR.
vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes.
vji_rti  out  1  run-test-idle indication.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_dr 0, vji_tck 0, vji_tdi 0, vji_ir_in 0, all strobes 0, vji_rti 1, counters 0.
- FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RSP -> IDLE. With cmd_ir_only: IDLE -> UIR -> RSP.
- Tck period: one tck period is 2*TCK_DIV clk cycles. The low phase comes first (TCK_DIV cycles with tck=0), then the high phase (TCK_DIV cycles with tck=1).
- Strobe timing: each of UIR, CDR and UDR lasts exactly one tck period, with its strobe high for the whole period. SDR lasts DR_WIDTH tck periods with vji_sdr high throughout.
- On accept: latch cmd_ir into vji_ir_in, where it is held until the next accept. Latch cmd_dr into the shift register. Clear the capture register. vji_rti drops to 0 in the next cycle.
- Shifting in SDR:
  - vji_tdi = shift[0] during the low phase.
  - On the last clk of the low phase, sample vji_tdo into the capture register: capture <= {tdo, capture[W-1:1]}.
  - On the high-to-low transition, shift <= shift >> 1.
  - The bit counter ends after DR_WIDTH periods. vji_tdi = 0 outside SDR.
- Latency: accept at cycle 0; rsp_valid rises at cycle 1 + (DR_WIDTH+3)*2*TCK_DIV. For defaults that is cycle 165. IR-only: cycle 1 + 2*TCK_DIV.
- Leaving SDR/UDR: tck is 0 and all strobes are 0 when the FSM leaves UDR; likewise when it leaves UIR in IR-only mode.
- RSP: rsp_dr = capture, held stable while rsp_valid=1; IR-only returns rsp_dr = 0. Stay in RSP until rsp_ready. Return to IDLE the next cycle with cmd_ready=1 and vji_rti=1.
- No pipelining: a new command cannot be accepted in the same cycle the response is consumed.
- cmd_valid while busy is ignored; cmd_* need not be held after accept.
- Reset asserted mid-scan: immediate return to reset values, and the scan is abandoned with no response. The slave sees tck stop low and vji_sdr drop.
- TCK_DIV=1: the sample and the rising edge occur on consecutive clks. This is legal and must be supported.

Decomposition:
- Package cpu_debug_host_pkg:
  - State enum: IDLE, UIR, CDR, SDR, UDR, RSP.
  - IR codes: IR_OCIMEM=2'b00, IR_TRACEMEM=2'b01, IR_BREAK=2'b10, IR_TRACECTRL=2'b11.
  - DR_WIDTH default constant.
- One sub-module, cpu_debug_host_tck_gen. It holds the half-period counter and produces vji_tck plus single-cycle pulses sample_en (last low-phase clk) and fall_en (high-to-low). It is enabled by the FSM and cleared on reset or disable.

Test Plan:
1. Reset: hold reset_n=0 with cmd_valid=1 -> cmd_ready=1, vji_rti=1, tck=0, all strobes 0, no accept. Release reset -> accept happens on the next cycle.
2. DR scan against a behavioural 38-bit slave shift register (preloaded 38'h2A_5A5A_5A5A, tdo=sr[0], shift on tck posedge when sdr):
   - Send cmd_ir=2'b10, cmd_dr=38'h15_1234_5678.
   - Expect rsp_valid at cycle 165, rsp_dr=38'h2A_5A5A_5A5A, and the slave register finishes at 38'h15_1234_5678.
   - Expect exactly 41 tck rising edges, with uir/cdr/sdr/udr durations of 4/4/152/4 clks.
3. IR-only: cmd_ir=2'b01, cmd_ir_only=1 -> one uir period, no cdr/sdr/udr, rsp_valid at cycle 5, rsp_dr=0, vji_ir_in=2'b01 held afterwards.
4. Backpressure: keep rsp_ready=0 for 20 cycles -> rsp_valid and rsp_dr stay stable, cmd_ready=0, tck idle low. Raise rsp_ready -> IDLE next cycle.
5. Reset mid-SDR: assert reset_n=0 at bit 17 -> tck=0, sdr=0, rsp_valid=0 in the same cycle. A following full scan completes correctly.
6. TCK_DIV=1: repeat scenario 2 -> rsp_valid at cycle 83 with an identical rsp_dr.
